mux2_rr_arbiter: RTL and testbench

- Shares one N-bit datapath between two valid/ready requesters (X side, Y side) using round-robin arbitration with packet locking.
- Drives the select of a 2:1 datapath mux and registers the selected beat into a single-entry output stage.
- Sits between two producer pipelines and one downstream consumer, e.g. two operand sources feeding one ALU/register-file write port.

---
 rtl/mux2_rr_arbiter_pkg.sv | 23 ++
 rtl/mux2_rr_arbiter_if.sv | 41 ++++
 rtl/mux2_rr_arbiter_mux.sv | 11 +
 rtl/mux2_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux2_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin arbiter: FSM states and
// the source tag carried with every registered beat.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_X = 2'd1,
        LOCK_Y = 2'd2
    } state_t;

    localparam logic SRC_X = 1'b0;
    localparam logic SRC_Y = 1'b1;

    // Lock state that holds the grant on the given source for the rest of a packet.
    function automatic state_t lock_of(input logic src);
        return (src == SRC_Y) ? LOCK_Y : LOCK_X;
    endfunction

    function automatic logic other_src(input logic src);
        return (src == SRC_Y) ? SRC_X : SRC_Y;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two producers, the arbiter and one consumer.
// master = producer/consumer side, slave = arbiter side.
interface mux2_rr_arbiter_if #(
    parameter int N = 32
);
    logic         x_valid;
    logic [N-1:0] x_data;
    logic         x_last;
    logic         x_ready;

    logic         y_valid;
    logic [N-1:0] y_data;
    logic         y_last;
    logic         y_ready;

    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         out_src;
    logic         out_ready;

    logic         sel;

    modport master (
        output x_valid, x_data, x_last,
        output y_valid, y_data, y_last,
        output out_ready,
        input  x_ready, y_ready,
        input  out_valid, out_data, out_last, out_src,
        input  sel
    );

    modport slave (
        input  x_valid, x_data, x_last,
        input  y_valid, y_data, y_last,
        input  out_ready,
        output x_ready, y_ready,
        output out_valid, out_data, out_last, out_src,
        output sel
    );
endinterface

// File: rtl/mux2_rr_arbiter_mux.sv
// Plain 2:1 datapath mux; sel=0 passes a, sel=1 passes b.
module mux_2to1 #(
    parameter int N_DATA = 33
) (
    input  logic [N_DATA-1:0] a,
    input  logic [N_DATA-1:0] b,
    input  logic              sel,
    output logic [N_DATA-1:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter with packet locking between two valid/ready requesters,
// feeding a single-entry registered output stage through a 2:1 mux.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mux2_rr_arbiter_if.slave bus
);

    state_t       state;
    logic         prio;
    logic         can_load;
    logic         grant_x;
    logic         grant_y;
    logic         sel_int;
    logic         x_fire;
    logic         y_fire;
    logic         vld_p0;
    logic [N:0]   beat_p0;

    assign can_load = !bus.out_valid || bus.out_ready;

    // In IDLE the grant is the arbitration result itself, so the two readies
    // can never be high together; once locked, only the owner is considered.
    always_comb begin
        grant_x = 1'b0;
        grant_y = 1'b0;
        case (state)
            IDLE: begin
                grant_x = bus.x_valid && (!bus.y_valid || (prio == SRC_X));
                grant_y = bus.y_valid && (!bus.x_valid || (prio == SRC_Y));
            end
            LOCK_X:  grant_x = 1'b1;
            LOCK_Y:  grant_y = 1'b1;
            default: ;
        endcase
    end

    assign sel_int     = rst_n && grant_y;
    assign bus.sel     = sel_int;
    assign bus.x_ready = rst_n && can_load && grant_x;
    assign bus.y_ready = rst_n && can_load && grant_y;

    assign x_fire = bus.x_valid && bus.x_ready;
    assign y_fire = bus.y_valid && bus.y_ready;
    assign vld_p0 = x_fire || y_fire;

    mux_2to1 #(
        .N_DATA (N + 1)
    ) u_mux (
        .a   ({bus.x_last, bus.x_data}),
        .b   ({bus.y_last, bus.y_data}),
        .sel (sel_int),
        .y   (beat_p0)
    );

    // ---- p0 -> p1: arbitration state and output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            prio          <= SRC_X;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_src   <= SRC_X;
        end else begin
            if (vld_p0) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= beat_p0[N-1:0];
                bus.out_last  <= beat_p0[N];
                bus.out_src   <= sel_int;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            // A last beat always releases the lock and hands priority over.
            if (vld_p0) begin
                if (beat_p0[N]) begin
                    state <= IDLE;
                    prio  <= other_src(sel_int);
                end else begin
                    state <= lock_of(sel_int);
                end
            end
        end
    end

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.x_ready && bus.y_ready));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_last)
             && $stable(bus.out_src)));

    a_no_foreign_in_lock: assert property (@(posedge clk) disable iff (!rst_n)
        ((state == LOCK_X) |-> !bus.y_ready) and ((state == LOCK_Y) |-> !bus.x_ready));

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomised bench for mux2_rr_arbiter: a rule-level arbitration model predicts
// readies and pushes expected beats; an independent monitor pops and compares.
module tb_mux2_rr_arbiter;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux2_rr_arbiter_if #(.N(N)) bus ();

    mux2_rr_arbiter #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [N+1:0] sb[$];          // {src, last, data}
    logic [N:0]   xq[$];          // pending X beats {last, data}
    logic [N:0]   yq[$];

    bit x_en = 1'b1, y_en = 1'b1;
    int vld_pct = 100, rdy_pct = 100;
    bit x_hold = 1'b0, y_hold = 1'b0;

    // Reference: who owns the datapath (-1 nobody, 0 X, 1 Y), whose turn it is
    // on a tie, and whether the output holding slot is occupied.
    int owner = -1;
    int turn  = 0;
    bit m_ov  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int side, input int len, input logic [N-1:0] base);
        for (int i = 0; i < len; i++) begin
            logic [N:0] b;
            b = {(i == len - 1), base + N'(i)};
            if (side == 0) xq.push_back(b);
            else           yq.push_back(b);
        end
    endtask

    task automatic model_reset();
        xq.delete(); yq.delete(); sb.delete();
        owner = -1; turn = 0; m_ov = 1'b0;
        x_hold = 1'b0; y_hold = 1'b0;
    endtask

    task automatic cycle();
        logic cl, gx, gy, ex, ey, xf, yf;
        logic [N:0] junk;
        logic [N:0] b;
        @(negedge clk);
        bus.out_ready = ($urandom_range(99) < rdy_pct);
        if (!x_hold) begin
            if (x_en && xq.size() > 0 && $urandom_range(99) < vld_pct) begin
                bus.x_valid = 1'b1;
                {bus.x_last, bus.x_data} = xq[0];
            end else begin
                junk = {1'($urandom), 32'($urandom)};
                bus.x_valid = 1'b0;
                {bus.x_last, bus.x_data} = junk;
            end
        end
        if (!y_hold) begin
            if (y_en && yq.size() > 0 && $urandom_range(99) < vld_pct) begin
                bus.y_valid = 1'b1;
                {bus.y_last, bus.y_data} = yq[0];
            end else begin
                junk = {1'($urandom), 32'($urandom)};
                bus.y_valid = 1'b0;
                {bus.y_last, bus.y_data} = junk;
            end
        end
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(m_ov));
        cl = !m_ov || bus.out_ready;
        gx = 1'b0; gy = 1'b0;
        if (owner == 0)      gx = 1'b1;
        else if (owner == 1) gy = 1'b1;
        else begin
            gx = bus.x_valid && (!bus.y_valid || turn == 0);
            gy = bus.y_valid && (!bus.x_valid || turn == 1);
        end
        ex = cl && gx;
        ey = cl && gy;
        check("x_ready", 64'(bus.x_ready), 64'(ex));
        check("y_ready", 64'(bus.y_ready), 64'(ey));
        check("sel", 64'(bus.sel), 64'(gy));
        xf = bus.x_valid && ex;
        yf = bus.y_valid && ey;
        if (xf) begin
            b = xq.pop_front();
            sb.push_back({1'b0, b});
            if (b[N]) begin owner = -1; turn = 1; end
            else owner = 0;
        end
        if (yf) begin
            b = yq.pop_front();
            sb.push_back({1'b1, b});
            if (b[N]) begin owner = -1; turn = 0; end
            else owner = 1;
        end
        if (xf || yf)          m_ov = 1'b1;
        else if (bus.out_ready) m_ov = 1'b0;
        x_hold = bus.x_valid && !xf;
        y_hold = bus.y_valid && !yf;
    endtask

    // Monitor: pops one expected beat per output handshake and checks hold stability.
    initial begin
        logic [N+1:0] exp;
        logic [N:0]   pd;
        logic         pv, pr;
        pv = 1'b0; pr = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            if (pv && !pr)
                check("hold", 64'({bus.out_valid, bus.out_last, bus.out_data}), 64'({1'b1, pd}));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: got %0h expected none at %0t", bus.out_data, $time);
                end else begin
                    exp = sb.pop_front();
                    check("beat", 64'({bus.out_src, bus.out_last, bus.out_data}), 64'(exp));
                end
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            pd = {bus.out_last, bus.out_data};
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        bus.x_valid = 1'b1; bus.x_data = 32'hDEAD_0001; bus.x_last = 1'b0;
        bus.y_valid = 1'b1; bus.y_data = 32'hDEAD_0002; bus.y_last = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data",  64'(bus.out_data),  64'(0));
        check("rst_out_last",  64'(bus.out_last),  64'(0));
        check("rst_out_src",   64'(bus.out_src),   64'(0));
        check("rst_x_ready",   64'(bus.x_ready),   64'(0));
        check("rst_y_ready",   64'(bus.y_ready),   64'(0));
        check("rst_sel",       64'(bus.sel),       64'(0));
        bus.x_valid = 1'b0; bus.y_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single 3-beat X packet
        push_pkt(0, 3, 32'hA1);
        repeat (6) cycle();

        // Back-to-back single-beat packets on both sides
        for (int i = 0; i < 4; i++) begin
            push_pkt(0, 1, 32'h1111_0000 + 32'(i));
            push_pkt(1, 1, 32'h2222_0000 + 32'(i));
        end
        repeat (10) cycle();

        // Y arrives while an X packet is in flight
        push_pkt(0, 4, 32'h3300_0000);
        push_pkt(1, 2, 32'h4400_0000);
        y_en = 1'b0;
        repeat (2) cycle();
        y_en = 1'b1;
        repeat (8) cycle();

        // Output backpressure mid-packet
        push_pkt(0, 6, 32'h5500_0000);
        repeat (2) cycle();
        rdy_pct = 0;
        repeat (5) cycle();
        rdy_pct = 100;
        repeat (8) cycle();

        // X gap mid-packet with Y waiting
        push_pkt(0, 5, 32'h6600_0000);
        push_pkt(1, 1, 32'h7700_0000);
        repeat (2) cycle();
        x_en = 1'b0;
        repeat (3) cycle();
        x_en = 1'b1;
        repeat (8) cycle();

        // Randomised traffic
        vld_pct = 70; rdy_pct = 60;
        for (int c = 0; c < 400; c++) begin
            if (xq.size() < 3) push_pkt(0, $urandom_range(1, 4), 32'($urandom));
            if (yq.size() < 3) push_pkt(1, $urandom_range(1, 4), 32'($urandom));
            cycle();
        end

        // Reset mid-packet
        vld_pct = 100; rdy_pct = 100;
        xq.delete(); yq.delete();
        repeat (12) cycle();
        push_pkt(0, 6, 32'h8800_0000);
        repeat (3) cycle();
        @(negedge clk);
        bus.x_valid = 1'b1;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_x_ready",   64'(bus.x_ready),   64'(0));
        check("midrst_y_ready",   64'(bus.y_ready),   64'(0));
        model_reset();
        bus.x_valid = 1'b0; bus.y_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_pkt(1, 2, 32'h9900_0000);
        push_pkt(0, 1, 32'hAA00_0000);
        push_pkt(1, 1, 32'hBB00_0000);

        // Drain everything still pending
        budget = 200;
        while ((xq.size() > 0 || yq.size() > 0 || sb.size() > 0 || m_ov) && budget > 0) begin
            cycle();
            budget--;
        end
        @(negedge clk);
        #3;
        check("drain_budget", 64'(budget > 0), 64'(1));
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
